bids22_round_ctrl: RTL

Host-side round sequencer for the bids22 auction datapath. It accepts one round request (unlock key, three bidder balances, bid-window length), then issues the configuration ops over the C_op/C_data port. It opens and closes the bid window on C_start, captures winner and maxBid at roundOver, and returns one result record through a valid/ready handshake. It aborts cleanly on datapath error or on timeout.

---
 rtl/bids22_round_ctrl.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bids22_round_ctrl.sv
// bids22 round sequencer: unlocks and loads the datapath, runs the bid window,
// then returns one winner/maxBid record through a valid/ready handshake.
module bids22_round_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_key,
    input  logic [31:0] req_xbal,
    input  logic [31:0] req_ybal,
    input  logic [31:0] req_zbal,
    input  logic [15:0] req_duration,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic        ready,
    input  logic [2:0]  err,
    input  logic        roundOver,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    input  logic [31:0] maxBid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_winner,
    output logic [31:0] res_maxbid,
    output logic [2:0]  res_err,
    output logic        res_timeout
);

    localparam logic [3:0] OP_UNLOCK = 4'd1;
    localparam logic [3:0] OP_LOCK   = 4'd2;
    localparam logic [3:0] OP_LOAD_X = 4'd3;
    localparam logic [3:0] OP_LOAD_Y = 4'd4;
    localparam logic [3:0] OP_LOAD_Z = 4'd5;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_OPEN,
        S_WAIT_OVER,
        S_RESULT
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [2:0]    r_idx;
    logic [31:0]   r_key;
    logic [31:0]   r_xbal;
    logic [31:0]   r_ybal;
    logic [31:0]   r_zbal;
    logic [15:0]   r_dur;
    logic [15:0]   r_cnt;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_c_op;
    logic [31:0]   r_c_data;
    logic          r_c_start;
    logic          r_res_valid;
    logic [1:0]    r_res_winner;
    logic [31:0]   r_res_maxbid;
    logic [2:0]    r_res_err;
    logic          r_res_timeout;

    logic          w_accept;
    logic [2:0]    w_idx_nx;
    logic [15:0]   w_cnt_nx;
    logic [TW-1:0] w_tcnt_nx;
    logic [3:0]    w_c_op_nx;
    logic [31:0]   w_c_data_nx;
    logic          w_c_start_nx;
    logic          w_res_valid_nx;
    logic [1:0]    w_res_winner_nx;
    logic [31:0]   w_res_maxbid_nx;
    logic [2:0]    w_res_err_nx;
    logic          w_res_timeout_nx;
    logic [3:0]    w_op;
    logic [31:0]   w_opdata;
    logic [1:0]    w_win;

    assign req_ready   = (r_state == S_IDLE);
    assign C_op        = r_c_op;
    assign C_data      = r_c_data;
    assign C_start     = r_c_start;
    assign res_valid   = r_res_valid;
    assign res_winner  = r_res_winner;
    assign res_maxbid  = r_res_maxbid;
    assign res_err     = r_res_err;
    assign res_timeout = r_res_timeout;

    assign w_win = X_win ? 2'd1 :
                   Y_win ? 2'd2 :
                   Z_win ? 2'd3 : 2'd0;

    // Op code and operand for the current position in the config sequence.
    always_comb begin
        w_op     = OP_LOCK;
        w_opdata = r_key;
        unique case (r_idx)
            3'd0: begin
                w_op     = OP_UNLOCK;
                w_opdata = r_key;
            end
            3'd1: begin
                w_op     = OP_LOAD_X;
                w_opdata = r_xbal;
            end
            3'd2: begin
                w_op     = OP_LOAD_Y;
                w_opdata = r_ybal;
            end
            3'd3: begin
                w_op     = OP_LOAD_Z;
                w_opdata = r_zbal;
            end
            default: begin
                w_op     = OP_LOCK;
                w_opdata = r_key;
            end
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_next_state     = r_state;
        w_accept         = 1'b0;
        w_idx_nx         = r_idx;
        w_cnt_nx         = r_cnt;
        w_tcnt_nx        = r_tcnt;
        w_c_op_nx        = 4'd0;
        w_c_data_nx      = 32'd0;
        w_c_start_nx     = 1'b0;
        w_res_valid_nx   = r_res_valid;
        w_res_winner_nx  = r_res_winner;
        w_res_maxbid_nx  = r_res_maxbid;
        w_res_err_nx     = r_res_err;
        w_res_timeout_nx = r_res_timeout;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept         = 1'b1;
                    w_next_state     = S_ISSUE;
                    w_idx_nx         = 3'd0;
                    w_res_winner_nx  = 2'd0;
                    w_res_maxbid_nx  = 32'd0;
                    w_res_err_nx     = 3'd0;
                    w_res_timeout_nx = 1'b0;
                end
            end
            S_ISSUE: begin
                if (ready) begin
                    w_c_op_nx    = w_op;
                    w_c_data_nx  = w_opdata;
                    w_next_state = S_CHECK;
                end else if (r_tcnt == TLIM) begin
                    w_res_timeout_nx = 1'b1;
                    w_next_state     = S_RESULT;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (err != 3'd0) begin
                    w_res_err_nx = err;
                    w_next_state = S_RESULT;
                end else if (r_idx == 3'd4) begin
                    w_cnt_nx     = (r_dur == 16'd0) ? 16'd1 : r_dur;
                    w_next_state = S_OPEN;
                end else begin
                    w_idx_nx     = r_idx + 3'd1;
                    w_next_state = S_ISSUE;
                end
            end
            S_OPEN: begin
                if (r_cnt != 16'd0) begin
                    w_c_start_nx = 1'b1;
                    w_cnt_nx     = r_cnt - 16'd1;
                end else begin
                    w_next_state = S_WAIT_OVER;
                end
            end
            S_WAIT_OVER: begin
                if (roundOver) begin
                    w_res_winner_nx = w_win;
                    w_res_maxbid_nx = maxBid;
                    w_next_state    = S_RESULT;
                end else if (r_tcnt == TLIM) begin
                    w_res_timeout_nx = 1'b1;
                    w_next_state     = S_RESULT;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            S_RESULT: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nx = 1'b0;
                    w_next_state   = S_IDLE;
                end else begin
                    w_res_valid_nx = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_next_state != r_state) begin
            w_tcnt_nx = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= 3'd0;
            r_key         <= 32'd0;
            r_xbal        <= 32'd0;
            r_ybal        <= 32'd0;
            r_zbal        <= 32'd0;
            r_dur         <= 16'd0;
            r_cnt         <= 16'd0;
            r_tcnt        <= '0;
            r_c_op        <= 4'd0;
            r_c_data      <= 32'd0;
            r_c_start     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_winner  <= 2'd0;
            r_res_maxbid  <= 32'd0;
            r_res_err     <= 3'd0;
            r_res_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key  <= req_key;
                r_xbal <= req_xbal;
                r_ybal <= req_ybal;
                r_zbal <= req_zbal;
                r_dur  <= req_duration;
            end
            r_idx         <= w_idx_nx;
            r_cnt         <= w_cnt_nx;
            r_tcnt        <= w_tcnt_nx;
            r_c_op        <= w_c_op_nx;
            r_c_data      <= w_c_data_nx;
            r_c_start     <= w_c_start_nx;
            r_res_valid   <= w_res_valid_nx;
            r_res_winner  <= w_res_winner_nx;
            r_res_maxbid  <= w_res_maxbid_nx;
            r_res_err     <= w_res_err_nx;
            r_res_timeout <= w_res_timeout_nx;
        end
    end

endmodule
